// File: rtl/echo_tap_sequencer.sv
// Multi-tap echo controller: clears a single-port delay RAM after reset, then runs
// a read-read-read-write schedule per strobe with feedback applied to tap 0.
module echo_tap_sequencer #(
    parameter int W      = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strobe,
    input  logic [W-1:0]      sample_in,
    input  logic [ADDR_W-1:0] delay0,
    input  logic [ADDR_W-1:0] delay1,
    input  logic [ADDR_W-1:0] delay2,
    input  logic [7:0]        feedback,
    output logic [W-1:0]      tap_out0,
    output logic [W-1:0]      tap_out1,
    output logic [W-1:0]      tap_out2,
    output logic [W-1:0]      mix_out,
    output logic              done,
    output logic              busy,
    output logic              overrun,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [W-1:0]      ram_wdata,
    input  logic [W-1:0]      ram_rdata,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_RD0   = 3'd2,
        S_RD1   = 3'd3,
        S_RD2   = 3'd4,
        S_CAP   = 3'd5,
        S_WR    = 3'd6
    } state_t;

    localparam logic signed [W+1:0] SAT_MAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] SAT_MIN = {3'b111, {(W-1){1'b0}}};

    state_t state, state_n;

    logic [ADDR_W-1:0]   clr_cnt;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   d0_q, d1_q, d2_q;
    logic [7:0]          fb_q;
    logic signed [W-1:0] sample_q;
    logic signed [W-1:0] tap0_q, tap1_q, tap2_q;
    logic signed [W-1:0] wdata_q;

    logic signed [8:0]   fb_ext;
    logic signed [W+8:0] fb_prod;
    logic signed [W+8:0] fb_shift;
    logic signed [W+1:0] wsum;
    logic signed [W+1:0] msum;
    logic signed [W-1:0] wdata_n;
    logic signed [W-1:0] mix_n;

    logic [ADDR_W-1:0]   addr_c;
    logic                we_c;
    logic [W-1:0]        wdata_c;

    // Feedback gain is unsigned Q0.8, so it is zero-extended before the signed multiply.
    assign fb_ext   = {1'b0, fb_q};
    assign fb_prod  = (W+9)'(tap0_q) * (W+9)'(fb_ext);
    assign fb_shift = fb_prod >>> 8;
    assign wsum     = (W+2)'(sample_q) + (W+2)'(fb_shift);
    assign msum     = (W+2)'(tap0_q) + (W+2)'(tap1_q) + (W+2)'(tap2_q);

    always_comb begin
        wdata_n = wsum[W-1:0];
        if (wsum > SAT_MAX) begin
            wdata_n = SAT_MAX[W-1:0];
        end else if (wsum < SAT_MIN) begin
            wdata_n = SAT_MIN[W-1:0];
        end
    end

    always_comb begin
        mix_n = msum[W-1:0];
        if (msum > SAT_MAX) begin
            mix_n = SAT_MAX[W-1:0];
        end else if (msum < SAT_MIN) begin
            mix_n = SAT_MIN[W-1:0];
        end
    end

    always_comb begin
        state_n = state;
        addr_c  = wr_ptr;
        we_c    = 1'b0;
        wdata_c = '0;
        case (state)
            S_CLEAR: begin
                addr_c = clr_cnt;
                we_c   = 1'b1;
                if (clr_cnt == '1) begin
                    state_n = S_IDLE;
                end
            end
            S_IDLE: begin
                if (strobe) begin
                    state_n = S_RD0;
                end
            end
            S_RD0: begin
                addr_c  = wr_ptr - d0_q;
                state_n = S_RD1;
            end
            S_RD1: begin
                addr_c  = wr_ptr - d1_q;
                state_n = S_RD2;
            end
            S_RD2: begin
                addr_c  = wr_ptr - d2_q;
                state_n = S_CAP;
            end
            S_CAP: begin
                state_n = S_WR;
            end
            S_WR: begin
                we_c    = 1'b1;
                wdata_c = wdata_q;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_CLEAR;
            end
        endcase
    end

    // Gating with rst keeps an in-flight write from reaching the RAM on the abort cycle.
    assign ram_we    = we_c & ~rst;
    assign ram_addr  = rst ? '0 : addr_c;
    assign ram_wdata = rst ? '0 : wdata_c;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_CLEAR;
            clr_cnt  <= '0;
            wr_ptr   <= '0;
            d0_q     <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            fb_q     <= '0;
            sample_q <= '0;
            tap0_q   <= '0;
            tap1_q   <= '0;
            tap2_q   <= '0;
            wdata_q  <= '0;
            tap_out0 <= '0;
            tap_out1 <= '0;
            tap_out2 <= '0;
            mix_out  <= '0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state <= state_n;
            done  <= (state == S_WR);
            if (strobe && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                end
                S_IDLE: begin
                    if (strobe) begin
                        sample_q <= sample_in;
                        d0_q     <= delay0;
                        d1_q     <= delay1;
                        d2_q     <= delay2;
                        fb_q     <= feedback;
                    end
                end
                S_RD1: begin
                    tap0_q <= ram_rdata;
                end
                S_RD2: begin
                    tap1_q <= ram_rdata;
                end
                S_CAP: begin
                    tap2_q  <= ram_rdata;
                    wdata_q <= wdata_n;
                end
                S_WR: begin
                    tap_out0 <= tap0_q;
                    tap_out1 <= tap1_q;
                    tap_out2 <= tap2_q;
                    mix_out  <= mix_n;
                    wr_ptr   <= wr_ptr + ADDR_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_echo_tap_sequencer.sv
// Bench for echo_tap_sequencer: behavioural history model checked every cycle,
// directed scenarios pinned with hand-computed values, then randomized strobes.
module tb_echo_tap_sequencer;
    localparam int W     = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          strobe = 1'b0;
    logic [W-1:0]  sample_in = '0;
    logic [AW-1:0] delay0 = '0, delay1 = '0, delay2 = '0;
    logic [7:0]    feedback = '0;
    logic [W-1:0]  tap_out0, tap_out1, tap_out2, mix_out;
    logic          done, busy, overrun;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [W-1:0]  ram_wdata;
    logic [W-1:0]  ram_rdata = '0;
    logic [2:0]    state_dbg;
    logic [W-1:0]  mem [DEPTH];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    echo_tap_sequencer #(.W(W), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .strobe(strobe), .sample_in(sample_in),
        .delay0(delay0), .delay1(delay1), .delay2(delay2), .feedback(feedback),
        .tap_out0(tap_out0), .tap_out1(tap_out1), .tap_out2(tap_out2), .mix_out(mix_out),
        .done(done), .busy(busy), .overrun(overrun),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .state_dbg(state_dbg)
    );

    // Single-port RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int fdiv256(input int p);
        if (p >= 0) return p / 256;
        return -((-p + 255) / 256);
    endfunction

    // ---------------- behavioural model ----------------
    int hist[$];              // samples written since the last clear, oldest first
    logic [W-1:0] exp_q[$];   // expected RAM write data, one per accepted strobe
    int cyc = 0;
    bit mvalid = 0;
    int clear_start = -100;
    int seq_t = -100;
    bit seq_live = 0;
    int cur_tap[3] = '{0, 0, 0};
    int cur_mix = 0;
    bit ovr_m = 0;
    int p_tap[3];
    int p_ra[3];
    int p_wa, p_mix, p_w, n_wr, sv;
    bit in_clr, in_seq;
    logic [W-1:0] ev;

    function automatic int tap_val(input int d);
        int de;
        int idx;
        de = (d == 0) ? DEPTH : d;
        idx = hist.size() - de;
        return (idx >= 0) ? hist[idx] : 0;
    endfunction

    always @(negedge clk) begin
        in_clr = (cyc >= clear_start) && (cyc < clear_start + DEPTH);
        in_seq = seq_live && (cyc >= seq_t + 1) && (cyc <= seq_t + 5);
        if (mvalid) begin
            check("busy", int'(busy), int'(in_clr || in_seq));
            check("done", int'(done), int'(seq_live && cyc == seq_t + 6));
            check("overrun", int'(overrun), int'(ovr_m));
            check("tap_out0", int'($signed(tap_out0)), cur_tap[0]);
            check("tap_out1", int'($signed(tap_out1)), cur_tap[1]);
            check("tap_out2", int'($signed(tap_out2)), cur_tap[2]);
            check("mix_out", int'($signed(mix_out)), cur_mix);
            if (rst) begin
                check("rst_ram_we", int'(ram_we), 0);
                check("rst_ram_addr", int'(ram_addr), 0);
            end else if (in_clr) begin
                check("clr_ram_we", int'(ram_we), 1);
                check("clr_ram_addr", int'(ram_addr), cyc - clear_start);
                check("clr_ram_wdata", int'(ram_wdata), 0);
            end else if (in_seq && cyc <= seq_t + 3) begin
                check("rd_ram_we", int'(ram_we), 0);
                check("rd_ram_addr", int'(ram_addr), p_ra[cyc - seq_t - 1]);
            end else if (in_seq && cyc == seq_t + 5) begin
                check("wr_ram_we", int'(ram_we), 1);
                check("wr_ram_addr", int'(ram_addr), p_wa);
                check("wr_queue_size", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    ev = exp_q.pop_front();
                    check("wr_ram_wdata", int'(ram_wdata), int'(ev));
                end
            end else begin
                check("idle_ram_we", int'(ram_we), 0);
            end
        end

        if (rst) begin
            mvalid = 1;
            clear_start = cyc + 1;
            seq_live = 0;
            hist.delete();
            exp_q.delete();
            cur_tap = '{0, 0, 0};
            cur_mix = 0;
            ovr_m = 0;
        end else if (mvalid) begin
            if (seq_live && cyc == seq_t + 5) begin
                cur_tap = p_tap;
                cur_mix = p_mix;
                hist.push_back(p_w);
            end
            if (strobe) begin
                if (in_clr || in_seq) begin
                    ovr_m = 1;
                end else begin
                    n_wr = hist.size();
                    p_tap[0] = tap_val(int'(delay0));
                    p_tap[1] = tap_val(int'(delay1));
                    p_tap[2] = tap_val(int'(delay2));
                    p_ra[0] = (n_wr - int'(delay0) + DEPTH) % DEPTH;
                    p_ra[1] = (n_wr - int'(delay1) + DEPTH) % DEPTH;
                    p_ra[2] = (n_wr - int'(delay2) + DEPTH) % DEPTH;
                    p_wa = n_wr % DEPTH;
                    sv = int'($signed(sample_in));
                    p_w = sat(sv + fdiv256(p_tap[0] * int'(feedback)));
                    exp_q.push_back(W'(p_w));
                    p_mix = sat(p_tap[0] + p_tap[1] + p_tap[2]);
                    seq_t = cyc;
                    seq_live = 1;
                end
            end
        end
        cyc++;
    end

    // ---------------- drivers ----------------
    task automatic pulse(input int s, input int d0, input int d1, input int d2, input int fb);
        @(posedge clk);
        #1;
        sample_in = W'(s);
        delay0 = AW'(d0);
        delay1 = AW'(d1);
        delay2 = AW'(d2);
        feedback = 8'(fb);
        strobe = 1'b1;
        @(posedge clk);
        #1 strobe = 1'b0;
    endtask

    task automatic strobe_wait(input int s, input int d0, input int d1, input int d2, input int fb,
                               output int t0, output int t1, output int t2, output int mx);
        int lat;
        bit got;
        pulse(s, d0, d1, d2, fb);
        got = 0;
        lat = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (done) got = 1;
        end
        check("done_latency", got ? lat : -1, 6);
        t0 = int'($signed(tap_out0));
        t1 = int'($signed(tap_out1));
        t2 = int'($signed(tap_out2));
        mx = int'($signed(mix_out));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (DEPTH + 1) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bc, nd, t0, t1, t2, mx, sg, k;
        int fb_exp[4] = '{1000, 500, 250, 125};

        // Clear after reset: busy for exactly DEPTH cycles, no done pulse.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        bc = 0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (!busy) break;
            bc++;
        end
        check("clear_busy_cycles", bc, 16);
        check("clear_no_done", nd, 0);

        // Impulse through three taps.
        do_reset();
        for (int n = 0; n <= 8; n++) begin
            strobe_wait((n == 0) ? 1000 : 0, 4, 2, 8, 0, t0, t1, t2, mx);
            if (n == 2) begin
                check("imp_s2_tap1", t1, 1000);
                check("imp_s2_tap0", t0, 0);
                check("imp_s2_mix", mx, 1000);
            end
            if (n == 4) begin
                check("imp_s4_tap0", t0, 1000);
                check("imp_s4_mix", mx, 1000);
            end
            if (n == 8) begin
                check("imp_s8_tap2", t2, 1000);
                check("imp_s8_tap1", t1, 0);
            end
        end

        // Feedback decay, positive then negative impulse.
        for (int pass = 0; pass < 2; pass++) begin
            sg = (pass == 0) ? 1 : -1;
            do_reset();
            for (int n = 0; n <= 16; n++) begin
                strobe_wait((n == 0) ? 1000 * sg : 0, 4, 1, 2, 128, t0, t1, t2, mx);
                if (n > 0 && n % 4 == 0) check("fb_tap0", t0, sg * fb_exp[n / 4 - 1]);
            end
        end

        // Saturation at both rails.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int n = 0; n <= 4; n++) begin
                strobe_wait((pass == 0) ? 32767 : -32768, 1, 2, 3, 255, t0, t1, t2, mx);
            end
            check("sat_tap0", t0, (pass == 0) ? 32767 : -32768);
            check("sat_tap2", t2, (pass == 0) ? 32767 : -32768);
            check("sat_mix", mx, (pass == 0) ? 32767 : -32768);
        end

        // Delay 0 reads the location about to be overwritten; pointer wraps.
        do_reset();
        for (int n = 0; n <= 16; n++) begin
            strobe_wait(n + 1, 0, 1, 2, 0, t0, t1, t2, mx);
            if (n == 15) check("wrap_s15_tap0", t0, 0);
            if (n == 16) begin
                check("wrap_s16_tap0", t0, 1);
                check("wrap_s16_tap1", t1, 16);
            end
        end

        // Strobe at c3 is dropped and flagged; sequence still completes.
        do_reset();
        pulse(100, 1, 2, 3, 0);
        @(posedge clk);
        pulse(555, 1, 2, 3, 0);
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("ovr_single_done", nd, 1);
        check("ovr_flag", int'(overrun), 1);

        // Reset at c4 aborts the sequence and restarts the clear.
        pulse(200, 1, 2, 3, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_overrun", int'(overrun), 0);
        check("abort_busy", int'(busy), 1);
        check("abort_wdata", int'(ram_wdata), 0);
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort_no_done", nd, 0);
        repeat (DEPTH + 2) @(posedge clk);

        // Randomized strobes with random spacing and occasional mid-run resets.
        for (int it = 0; it < 300; it++) begin
            k = $urandom_range(0, 7);
            repeat (k) @(posedge clk);
            if ($urandom_range(0, 59) == 0) begin
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end
            pulse(int'($urandom_range(0, 65535)) - 32768,
                  $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                  $urandom_range(0, DEPTH - 1), $urandom_range(0, 255));
        end
        repeat (12) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
